hdmi_i2c_target: RTL and testbench

HDMI_I2C_TARGET -- requirements
Module: hdmi_i2c_target

---
 rtl/hdmi_i2c_target.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_hdmi_i2c_target.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_i2c_target.sv
// hdmi_i2c_target: I2C register target with a 256x8 file and an auto-increment pointer.
// Define HDMI_I2C_TGT_FILTER_EN to add a FILT_LEN-sample glitch filter on SCL/SDA.
module hdmi_i2c_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h39,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  if (FILT_LEN < 2 || FILT_LEN > 8) begin : g_bad_filt
    $error("FILT_LEN must be in 2..8");
  end

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WACK,
    RDATA,
    RACK,
    IGNORE
  } state_e;

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_s;
  logic       sda_s;
  logic       scl_f;
  logic       sda_f;
  logic       scl_p_q;
  logic       sda_p_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

`ifdef HDMI_I2C_TGT_FILTER_EN
  logic [FILT_LEN-1:0] scl_hist_q;
  logic [FILT_LEN-1:0] sda_hist_q;
  logic                scl_flt_q;
  logic                sda_flt_q;

  // Output only follows a full window of identical samples.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[FILT_LEN-2:0], scl_s};
      sda_hist_q <= {sda_hist_q[FILT_LEN-2:0], sda_s};
      if (&scl_hist_q)
        scl_flt_q <= 1'b1;
      else if (~|scl_hist_q)
        scl_flt_q <= 1'b0;
      if (&sda_hist_q)
        sda_flt_q <= 1'b1;
      else if (~|sda_hist_q)
        sda_flt_q <= 1'b0;
    end
  end

  assign scl_f = scl_flt_q;
  assign sda_f = sda_flt_q;
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_f;
      sda_p_q <= sda_f;
    end
  end

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_rise  = scl_f & ~scl_p_q;
  assign scl_fall  = ~scl_f & scl_p_q;
  assign start_det = scl_f & scl_p_q & sda_p_q & ~sda_f;
  assign stop_det  = scl_f & scl_p_q & ~sda_p_q & sda_f;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] ptr_q, ptr_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       stb_q, stb_d;
  logic [7:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rf_we;
  logic [7:0] rf_q [256];
  logic [7:0] ptr_inc;
  logic [7:0] rd_cur;
  logic [7:0] rd_nxt;
  logic       rx_st;
  logic       byte_done;
  logic       addr_hit;

  assign ptr_inc   = ptr_q + 8'd1;
  assign rd_cur    = rf_q[ptr_q];
  assign rd_nxt    = rf_q[ptr_inc];
  assign byte_done = scl_fall && (cnt_q == 4'd8);
  assign addr_hit  = (sh_q[7:1] == DEV_ADDR) && (sh_q[7:1] != 7'h00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    stb_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rf_we   = 1'b0;
    rx_st   = (state_q == ADDR) || (state_q == PTR) ||
              (state_q == WDATA);

    if (rx_st && scl_rise && cnt_q != 4'd8) begin
      sh_d  = {sh_q[6:0], sda_f};
      cnt_d = cnt_q + 4'd1;
    end

    if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, IGNORE: oe_d = 1'b0;
        ADDR: begin
          if (byte_done) begin
            cnt_d = '0;
            if (addr_hit) begin
              state_d = ADDR_ACK;
              oe_d    = 1'b1;
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            oe_d  = 1'b0;
            if (sh_q[0]) begin
              state_d = RDATA;
              sh_d    = rd_cur;
              oe_d    = ~rd_cur[7];
            end else begin
              state_d = PTR;
            end
          end
        end
        PTR: begin
          if (byte_done) begin
            state_d = PTR_ACK;
            ptr_d   = sh_q;
            oe_d    = 1'b1;
            cnt_d   = '0;
          end
        end
        PTR_ACK, WACK: begin
          if (scl_fall) begin
            state_d = WDATA;
            oe_d    = 1'b0;
          end
        end
        WDATA: begin
          if (byte_done) begin
            state_d = WACK;
            oe_d    = 1'b1;
            rf_we   = 1'b1;
            stb_d   = 1'b1;
            waddr_d = ptr_q;
            wdata_d = sh_q;
            ptr_d   = ptr_inc;
            cnt_d   = '0;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              state_d = RACK;
              oe_d    = 1'b0;
              cnt_d   = '0;
            end else begin
              sh_d  = {sh_q[6:0], 1'b0};
              oe_d  = ~sh_q[6];
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        RACK: begin
          oe_d = 1'b0;
          if (scl_rise && sda_f) begin
            state_d = IGNORE;
          end else if (scl_fall) begin
            state_d = RDATA;
            ptr_d   = ptr_inc;
            sh_d    = rd_nxt;
            oe_d    = ~rd_nxt[7];
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ptr_q   <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 256; i++)
        rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[ptr_q] <= sh_q;
    end
  end

  assign sda_oe  = oe_q;
  assign wr_stb  = stb_q;
  assign wr_addr = waddr_q;
  assign wr_data = wdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_hdmi_i2c_target.sv
// tb_hdmi_i2c_target: bus-level I2C master driving the target, open-drain SDA,
// write scoreboard on wr_stb plus a register-file model for read-back.
`timescale 1ns/1ps
module tb_hdmi_i2c_target;

  localparam int Q = 10;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [15:0] wr_q[$];
  logic [7:0] rf_m [256];

  assign sda_line = sda_m & ~sda_oe;

  hdmi_i2c_target dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (wr_stb) begin
      if (wr_q.size() == 0)
        chk("wr_unexp", {31'd0, wr_stb}, 32'd0);
      else
        chk("wr_pulse", {wr_addr, wr_data}, {16'd0, wr_q.pop_front()});
    end
  end

  task automatic qw(input int n = 1);
    repeat (n * Q) @(negedge sys_clk);
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
    rf_m[a] = d;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qw();
    scl_m = 1'b1; qw();
    sda_m = 1'b0; qw();
    scl_m = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qw();
    scl_m = 1'b1; qw();
    sda_m = 1'b1; qw(2);
  endtask

  task automatic wr_byte(input logic [7:0] b, input bit glitch,
                         output bit ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      qw();
      scl_m = 1'b1;
      if (glitch && i == 4) begin
        repeat (Q / 2) @(negedge sys_clk);
        scl_m = 1'b0;
        @(negedge sys_clk);
        scl_m = 1'b1;
        repeat (2 * Q - Q / 2 - 1) @(negedge sys_clk);
      end else begin
        qw(2);
      end
      scl_m = 1'b0;
      qw();
    end
    sda_m = 1'b1; qw();
    scl_m = 1'b1; qw();
    ack = sda_oe;
    qw();
    scl_m = 1'b0; qw();
  endtask

  task automatic send(input logic [7:0] b, input bit exp_ack,
                      input string tag);
    bit a;
    wr_byte(b, 1'b0, a);
    chk(tag, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic rd_byte(input bit nack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      qw();
      scl_m = 1'b1; qw();
      b[i] = sda_line;
      qw();
      scl_m = 1'b0; qw();
    end
    sda_m = nack; qw();
    scl_m = 1'b1; qw(2);
    scl_m = 1'b0; qw();
    sda_m = 1'b1;
  endtask

  task automatic set_ptr_read(input logic [7:0] p);
    i2c_start();
    send(8'h72, 1'b1, "rp_addr");
    send(p, 1'b1, "rp_ptr");
    i2c_start();
    send(8'h73, 1'b1, "rp_raddr");
  endtask

  initial begin
    #(20ms);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    bit         a;
    for (int i = 0; i < 256; i++) rf_m[i] = 8'h00;

    repeat (5) @(negedge sys_clk);
    chk("rst_oe",   {31'd0, sda_oe}, 32'd0);
    chk("rst_stb",  {31'd0, wr_stb}, 32'd0);
    chk("rst_wa",   {24'd0, wr_addr}, 32'd0);
    chk("rst_wd",   {24'd0, wr_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    sys_rst_n = 1'b1;
    qw(2);

    // traffic with no START must be ignored
    scl_m = 1'b0; qw();
    wr_byte(8'h72, 1'b0, a);
    chk("idle_noack", {31'd0, a}, 32'd0);
    i2c_stop();

    // single write
    i2c_start();
    send(8'h72, 1'b1, "t1_addr");
    chk("t1_busy", {31'd0, busy}, 32'd1);
    send(8'h41, 1'b1, "t1_ptr");
    exp_wr(8'h41, 8'h10);
    send(8'h10, 1'b1, "t1_data");
    i2c_stop();
    chk("t1_busy_stop", {31'd0, busy}, 32'd0);

    i2c_start();
    send(8'h72, 1'b1, "pl_addr");
    send(8'h42, 1'b1, "pl_ptr");
    exp_wr(8'h42, 8'h20);
    send(8'h20, 1'b1, "pl_data");
    i2c_stop();
    i2c_start();
    send(8'h72, 1'b1, "pl_addr2");
    send(8'h01, 1'b1, "pl_ptr2");
    exp_wr(8'h01, 8'h5A);
    send(8'h5A, 1'b1, "pl_data2");
    i2c_stop();

    // burst write across pointer wrap, then Sr read at pointer
    i2c_start();
    send(8'h72, 1'b1, "t2_addr");
    send(8'hFE, 1'b1, "t2_ptr");
    exp_wr(8'hFE, 8'hAA);
    send(8'hAA, 1'b1, "t2_d0");
    exp_wr(8'hFF, 8'hBB);
    send(8'hBB, 1'b1, "t2_d1");
    exp_wr(8'h00, 8'hCC);
    send(8'hCC, 1'b1, "t2_d2");
    i2c_start();
    send(8'h73, 1'b1, "t2_raddr");
    rd_byte(1'b1, b);
    chk("t2_ptr_end", {24'd0, b}, {24'd0, rf_m[8'h01]});
    i2c_stop();

    // pointer write, Sr, two-byte read
    set_ptr_read(8'h41);
    rd_byte(1'b0, b);
    chk("t3_rd0", {24'd0, b}, {24'd0, rf_m[8'h41]});
    rd_byte(1'b1, b);
    chk("t3_rd1", {24'd0, b}, {24'd0, rf_m[8'h42]});
    chk("t3_oe_nack", {31'd0, sda_oe}, 32'd0);
    i2c_stop();

    // read across wrap
    set_ptr_read(8'hFF);
    rd_byte(1'b0, b);
    chk("t5_rdff", {24'd0, b}, {24'd0, rf_m[8'hFF]});
    rd_byte(1'b1, b);
    chk("t5_rd00", {24'd0, b}, {24'd0, rf_m[8'h00]});
    i2c_stop();

    // foreign address and general call
    i2c_start();
    send(8'h74, 1'b0, "t4_addr");
    send(8'h41, 1'b0, "t4_ptr");
    send(8'h55, 1'b0, "t4_data");
    chk("t4_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    i2c_start();
    send(8'h00, 1'b0, "t4_gcall");
    i2c_stop();

    // reset while driving a zero read bit
    set_ptr_read(8'h80);
    for (int i = 0; i < 4; i++) begin
      qw();
      scl_m = 1'b1; qw(2);
      scl_m = 1'b0; qw();
    end
    chk("t6_drive", {31'd0, sda_oe}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("t6_async_oe", {31'd0, sda_oe}, 32'd0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    for (int i = 0; i < 256; i++) rf_m[i] = 8'h00;
    qw();
    sys_rst_n = 1'b1;
    qw(2);
    i2c_start();
    send(8'h72, 1'b1, "t6_addr");
    send(8'h10, 1'b1, "t6_ptr");
    exp_wr(8'h10, 8'h33);
    send(8'h33, 1'b1, "t6_data");
    i2c_stop();
    set_ptr_read(8'h10);
    rd_byte(1'b1, b);
    chk("t6_rd", {24'd0, b}, {24'd0, rf_m[8'h10]});
    i2c_stop();
    set_ptr_read(8'h41);
    rd_byte(1'b1, b);
    chk("t6_rf_clr", {24'd0, b}, {24'd0, rf_m[8'h41]});
    i2c_stop();

`ifdef HDMI_I2C_TGT_FILTER_EN
    // SCL glitch mid-byte must be filtered out
    i2c_start();
    send(8'h72, 1'b1, "t7_addr");
    send(8'h20, 1'b1, "t7_ptr");
    exp_wr(8'h20, 8'hC3);
    wr_byte(8'hC3, 1'b1, a);
    chk("t7_ack", {31'd0, a}, 32'd1);
    i2c_stop();
    set_ptr_read(8'h20);
    rd_byte(1'b1, b);
    chk("t7_rd", {24'd0, b}, {24'd0, rf_m[8'h20]});
    i2c_stop();
`endif

    qw(4);
    chk("sb_empty", wr_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
